// File: rtl/alu_mc_param.sv
// ---------------------------------------------------------------------------
// alu_mc_param
// Registered, multi-cycle execute-stage ALU. It runs single-cycle logic and
// arithmetic ops plus an iterative unsigned multiply (HI/LO) and an iterative
// unsigned restoring divide (quotient/remainder), behind a start/busy/done
// handshake. The control unit stalls while busy is high.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request, accepted only while busy=0
//   aluOp      operation select, sampled with start
//   a, b       operands (WIDTH bits)
//   carryIn    carry into ADD only
//   busy       multi-cycle op in progress
//   done       one-cycle pulse, results updated this cycle
//   outputAlu  result / LO / quotient
//   outputHi   HI / remainder, 0 for other ops
//   carryOut   carry (ADD) / no-borrow (SUB), 0 otherwise
//   Z          zero flag
//   overflow   signed overflow (ADD/SUB only)
//   divByZero  DIVU with b=0
// ---------------------------------------------------------------------------
module alu_mc_param #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       aluOp,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryIn,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] outputAlu,
    output logic [WIDTH-1:0] outputHi,
    output logic             carryOut,
    output logic             Z,
    output logic             overflow,
    output logic             divByZero
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_NOR  = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_MULU = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    state_t               r_state, w_state_nxt;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_p;     // {HI,LO} for MULU, {remainder,quotient} for DIVU
    logic [WIDTH-1:0]     r_op;    // multiplicand or divisor

    logic [WIDTH-1:0]     w_b_op;
    logic                 w_cin;
    logic [WIDTH:0]       w_sum;
    logic                 w_ovf_raw;
    logic [WIDTH-1:0]     w_res;
    logic                 w_cout, w_ovf, w_z;

    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_nxt;
    logic [WIDTH:0]       w_div_sh;
    logic [WIDTH:0]       w_div_diff;
    logic [2*WIDTH-1:0]   w_div_nxt;

    // Single-cycle datapath; SUB and SLT share the a + ~b + 1 adder.
    always_comb begin
        w_b_op    = (aluOp == OP_ADD) ? b : ~b;
        w_cin     = (aluOp == OP_ADD) ? carryIn : 1'b1;
        w_sum     = {1'b0, a} + {1'b0, w_b_op} + {{WIDTH{1'b0}}, w_cin};
        w_ovf_raw = (a[WIDTH-1] == w_b_op[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
        w_res  = '0;
        w_cout = 1'b0;
        w_ovf  = 1'b0;
        w_z    = 1'b0;
        case (aluOp)
            OP_AND: begin w_res = a & b;    w_z = (w_res == '0); end
            OP_OR:  begin w_res = a | b;    w_z = (w_res == '0); end
            OP_XOR: begin w_res = a ^ b;    w_z = (w_res == '0); end
            OP_NOR: begin w_res = ~(a | b); w_z = (w_res == '0); end
            OP_ADD, OP_SUB: begin
                w_res  = w_sum[WIDTH-1:0];
                w_cout = w_sum[WIDTH];
                w_ovf  = w_ovf_raw;
                w_z    = (w_res == '0);
            end
            OP_SLT: begin
                w_res[0] = w_sum[WIDTH-1] ^ w_ovf_raw;
                w_z      = ~w_res[0];
            end
            default: ;
        endcase
    end

    // One shift-add / restoring-divide step per cycle.
    always_comb begin
        w_mul_sum  = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_op} : '0);
        w_mul_nxt  = {w_mul_sum, r_p[WIDTH-1:1]};
        w_div_sh   = {r_p[2*WIDTH-1:WIDTH], r_p[WIDTH-1]};
        w_div_diff = w_div_sh - {1'b0, r_op};
        if (w_div_sh >= {1'b0, r_op})
            w_div_nxt = {w_div_diff[WIDTH-1:0], r_p[WIDTH-2:0], 1'b1};
        else
            w_div_nxt = {w_div_sh[WIDTH-1:0], r_p[WIDTH-2:0], 1'b0};
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (aluOp == OP_MULU)
                        w_state_nxt = S_MUL;
                    else if (aluOp == OP_DIVU && b != '0)
                        w_state_nxt = S_DIV;
                end
            end
            S_MUL, S_DIV: if (r_cnt == CW'(1)) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_p       <= '0;
            r_op      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            outputAlu <= '0;
            outputHi  <= '0;
            carryOut  <= 1'b0;
            Z         <= 1'b0;
            overflow  <= 1'b0;
            divByZero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (aluOp == OP_MULU) begin
                            r_p  <= {{WIDTH{1'b0}}, b};
                            r_op <= a;
                            r_cnt <= CW'(WIDTH);
                            busy <= 1'b1;
                        end else if (aluOp == OP_DIVU && b != '0) begin
                            r_p  <= {{WIDTH{1'b0}}, a};
                            r_op <= b;
                            r_cnt <= CW'(WIDTH);
                            busy <= 1'b1;
                        end else if (aluOp == OP_DIVU) begin
                            outputAlu <= '1;
                            outputHi  <= a;
                            carryOut  <= 1'b0;
                            overflow  <= 1'b0;
                            Z         <= 1'b0;
                            divByZero <= 1'b1;
                            done      <= 1'b1;
                        end else begin
                            outputAlu <= w_res;
                            outputHi  <= '0;
                            carryOut  <= w_cout;
                            overflow  <= w_ovf;
                            Z         <= w_z;
                            divByZero <= 1'b0;
                            done      <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    r_p   <= w_mul_nxt;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        outputAlu <= w_mul_nxt[WIDTH-1:0];
                        outputHi  <= w_mul_nxt[2*WIDTH-1:WIDTH];
                        Z         <= (w_mul_nxt == '0);
                        carryOut  <= 1'b0;
                        overflow  <= 1'b0;
                        divByZero <= 1'b0;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                S_DIV: begin
                    r_p   <= w_div_nxt;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        outputAlu <= w_div_nxt[WIDTH-1:0];
                        outputHi  <= w_div_nxt[2*WIDTH-1:WIDTH];
                        Z         <= (w_div_nxt[WIDTH-1:0] == '0);
                        carryOut  <= 1'b0;
                        overflow  <= 1'b0;
                        divByZero <= 1'b0;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc_param.sv
// ---------------------------------------------------------------------------
// tb_alu_mc_param
// Self-checking bench for alu_mc_param: a 32-bit and an 8-bit instance,
// directed cases plus random operations compared with an arithmetic model.
// ---------------------------------------------------------------------------
module tb_alu_mc_param;

    logic        clk = 1'b0;
    logic        rst32_n, rst8_n;
    logic        start32, start8;
    logic [3:0]  op;
    logic [31:0] a_in, b_in;
    logic        cin;

    logic        busy32, done32, cout32, z32, ovf32, dbz32;
    logic [31:0] alu32, hi32;
    logic        busy8, done8, cout8, z8, ovf8, dbz8;
    logic [7:0]  alu8, hi8;

    int checks = 0;
    int errors = 0;

    logic        sel8;
    logic [31:0] o_alu, o_hi;
    logic        o_busy, o_done, o_cout, o_z, o_ovf, o_dbz;

    always #5 clk = ~clk;

    alu_mc_param #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst32_n), .start(start32), .aluOp(op),
        .a(a_in), .b(b_in), .carryIn(cin),
        .busy(busy32), .done(done32), .outputAlu(alu32), .outputHi(hi32),
        .carryOut(cout32), .Z(z32), .overflow(ovf32), .divByZero(dbz32));

    alu_mc_param #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst8_n), .start(start8), .aluOp(op),
        .a(a_in[7:0]), .b(b_in[7:0]), .carryIn(cin),
        .busy(busy8), .done(done8), .outputAlu(alu8), .outputHi(hi8),
        .carryOut(cout8), .Z(z8), .overflow(ovf8), .divByZero(dbz8));

    always_comb begin
        if (sel8) begin
            o_alu = {24'b0, alu8}; o_hi = {24'b0, hi8};
            o_busy = busy8; o_done = done8; o_cout = cout8;
            o_z = z8; o_ovf = ovf8; o_dbz = dbz8;
        end else begin
            o_alu = alu32; o_hi = hi32;
            o_busy = busy32; o_done = done32; o_cout = cout32;
            o_z = z32; o_ovf = ovf32; o_dbz = dbz32;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on WIDTH-bit values.
    function automatic void model(input int w, input logic [3:0] o,
                                  input logic [31:0] ai, input logic [31:0] bi, input logic c,
                                  output logic [31:0] alu, output logic [31:0] hi,
                                  output logic cy, output logic z, output logic ov,
                                  output logic dz, output int lat);
        longint unsigned m, ua, ub, p;
        longint sa, sb, s, smax, smin;
        m    = (64'd1 << w) - 1;
        ua   = ai & m;
        ub   = bi & m;
        sa   = (ua >= (64'd1 << (w - 1))) ? longint'(ua) - longint'(64'd1 << w) : longint'(ua);
        sb   = (ub >= (64'd1 << (w - 1))) ? longint'(ub) - longint'(64'd1 << w) : longint'(ub);
        smax = longint'(64'd1 << (w - 1)) - 1;
        smin = -longint'(64'd1 << (w - 1));
        alu = '0; hi = '0; cy = 0; ov = 0; dz = 0; lat = 0;
        case (o)
            4'b0000: alu = 32'(ua & ub);
            4'b0001: alu = 32'(ua | ub);
            4'b0011: alu = 32'(ua ^ ub);
            4'b0100: alu = 32'(~(ua | ub) & m);
            4'b0010: begin
                p   = ua + ub + longint'(c);
                alu = 32'(p & m);
                cy  = (p > m);
                s   = sa + sb + longint'(c);
                ov  = (s > smax) || (s < smin);
            end
            4'b0110: begin
                alu = 32'((ua - ub) & m);
                cy  = (ua >= ub);
                s   = sa - sb;
                ov  = (s > smax) || (s < smin);
            end
            4'b0111: alu = (sa < sb) ? 32'd1 : 32'd0;
            4'b1000: begin
                p   = ua * ub;
                alu = 32'(p & m);
                hi  = 32'(p >> w);
                lat = w;
            end
            4'b1001: begin
                if (ub == 0) begin
                    alu = 32'(m); hi = 32'(ua); dz = 1;
                end else begin
                    alu = 32'(ua / ub); hi = 32'(ua % ub); lat = w;
                end
            end
            default: ;
        endcase
        if (o == 4'b1000)      z = (alu == 0) && (hi == 0);
        else if (dz)           z = 0;
        else                   z = (alu == 0);
    endfunction

    // Issue one op at posedge+1, follow it to done, compare everything.
    // inject>0 drives an extra ADD start that many cycles into the op.
    task automatic run(input bit w8, input logic [3:0] o, input logic [31:0] ai,
                       input logic [31:0] bi, input logic c, input int inject, input string tag);
        logic [31:0] e_alu, e_hi;
        logic e_cy, e_z, e_ov, e_dz;
        int e_lat, lat, bcnt;
        bit seen;
        sel8 = w8;
        model(w8 ? 8 : 32, o, ai, bi, c, e_alu, e_hi, e_cy, e_z, e_ov, e_dz, e_lat);
        op = o; a_in = ai; b_in = bi; cin = c;
        if (w8) start8 = 1'b1; else start32 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0; start32 = 1'b0;
        lat = 0; bcnt = o_busy ? 1 : 0; seen = o_done;
        for (int i = 1; i <= 100 && !seen; i++) begin
            if (i == inject) begin
                op = 4'b0010; a_in = 32'd3; b_in = 32'd4; cin = 1'b0;
                if (w8) start8 = 1'b1; else start32 = 1'b1;
            end
            @(posedge clk); #1;
            start8 = 1'b0; start32 = 1'b0;
            lat++;
            if (o_busy) bcnt++;
            seen = o_done;
        end
        chk({tag, " done_seen"}, 64'(seen), 64'd1);
        chk({tag, " alu"},   64'(o_alu),  64'(e_alu));
        chk({tag, " hi"},    64'(o_hi),   64'(e_hi));
        chk({tag, " carry"}, 64'(o_cout), 64'(e_cy));
        chk({tag, " Z"},     64'(o_z),    64'(e_z));
        chk({tag, " ovf"},   64'(o_ovf),  64'(e_ov));
        chk({tag, " dbz"},   64'(o_dbz),  64'(e_dz));
        chk({tag, " latency"},    64'(lat),  64'(e_lat));
        chk({tag, " busy_cycles"}, 64'(bcnt), 64'(e_lat));
        @(posedge clk); #1;
        chk({tag, " done_pulse"}, 64'(o_done), 64'd0);
    endtask

    initial begin
        int dcnt;
        logic [3:0] ops [9] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h6, 4'h7, 4'h8, 4'h9};
        logic [3:0] ro;
        logic [31:0] ra, rb;

        rst32_n = 1'b0; rst8_n = 1'b0; start32 = 1'b0; start8 = 1'b0;
        op = '0; a_in = '0; b_in = '0; cin = 1'b0; sel8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst alu32",  64'(alu32), 64'd0);
        chk("rst hi32",   64'(hi32),  64'd0);
        chk("rst flags32", 64'({busy32, done32, cout32, z32, ovf32, dbz32}), 64'd0);
        chk("rst alu8",   64'({alu8, hi8, busy8, done8, z8}), 64'd0);
        rst32_n = 1'b1; rst8_n = 1'b1;
        @(posedge clk); #1;

        run(0, 4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0, "add_wrap");
        run(0, 4'b0110, 32'h8000_0000, 32'h0000_0001, 1'b0, 0, "sub_ovf");
        run(0, 4'b0111, 32'hA000_0000, 32'hB000_0000, 1'b0, 0, "slt");
        run(0, 4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 5, "mulu_max");
        run(0, 4'b1001, 32'd100, 32'd7, 1'b0, 0, "divu");
        run(0, 4'b1001, 32'd5, 32'd0, 1'b0, 0, "divu_by0");

        // back-to-back single-cycle ops with start held high
        sel8 = 1'b0;
        op = 4'b0000; a_in = 32'hF0F0_F0F0; b_in = 32'h0FF0_0FF0; start32 = 1'b1;
        @(posedge clk); #1;
        chk("b2b and done", 64'(done32), 64'd1);
        chk("b2b and alu",  64'(alu32),  64'h00F0_00F0);
        op = 4'b0100; a_in = '0; b_in = '0;
        @(posedge clk); #1;
        start32 = 1'b0;
        chk("b2b nor done", 64'(done32), 64'd1);
        chk("b2b nor alu",  64'(alu32),  64'hFFFF_FFFF);
        chk("b2b nor Z",    64'(z32),    64'd0);
        @(posedge clk); #1;
        chk("b2b done drop", 64'(done32), 64'd0);

        run(1, 4'b1000, 32'hFF, 32'hFF, 1'b0, 0, "mulu8_max");

        for (int n = 0; n < 40; n++) begin
            ro = ops[$urandom_range(0, 8)];
            ra = $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'd0 :
                 ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            run(n[0], ro, ra, rb, 1'($urandom_range(0, 1)), 0, $sformatf("rnd%0d_op%0h", n, ro));
        end

        // reset in the middle of a MULU
        run(0, 4'b0010, 32'd1, 32'd1, 1'b0, 0, "pre_rst_add");
        op = 4'b1000; a_in = 32'h1234_5678; b_in = 32'h9ABC_DEF0; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        repeat (14) @(posedge clk);
        #2;
        rst32_n = 1'b0;
        #1;
        chk("midrst alu", 64'(alu32), 64'd0);
        chk("midrst flags", 64'({busy32, done32, cout32, z32, ovf32, dbz32, hi32}), 64'd0);
        @(posedge clk); #1;
        rst32_n = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done32 || busy32) dcnt++;
        end
        chk("midrst no_done", 64'(dcnt), 64'd0);
        run(0, 4'b0010, 32'd3, 32'd4, 1'b0, 0, "post_rst_add");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_mc_param.md
Name: alu_mc_param

Overview:
- Parametrised, registered, multi-cycle successor to the 32-bit combinational MIPS ALU.
- Adds the following:
  - WIDTH generalisation.
  - XOR and NOR.
  - Signed overflow flag.
  - Iterative unsigned multiply (HI/LO) and unsigned divide (quotient/remainder).
  - A start/busy/done handshake.
- Sits in the execute stage; the control unit stalls on busy.

Parameters:
WIDTH, 32, operand/result width (>=4)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; accepted only when busy=0
aluOp  input  4  operation select (sampled with start)
a  input  WIDTH  operand A
b  input  WIDTH  operand B
carryIn  input  1  carry into ADD only
busy  output  1  multi-cycle op in progress
done  output  1  one-cycle pulse, results updated this cycle
outputAlu  output  WIDTH  result / LO / quotient
outputHi  output  WIDTH  HI / remainder; 0 for other ops
carryOut  output  1  carry (ADD) / no-borrow (SUB); 0 otherwise
Z  output  1  zero flag
overflow  output  1  signed overflow (ADD/SUB only)
divByZero  output  1  DIVU with b=0

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - All outputs 0, including Z.
  - Iteration counter and internal registers cleared.
  - Effective immediately; aborts any running op; no done is produced.
- Opcodes:
  - 0000 AND, 0001 OR, 0011 XOR, 0100 NOR.
  - 0010 ADD: {carryOut,outputAlu}=a+b+carryIn.
  - 0110 SUB: a+~b+1; carryIn ignored.
  - 0111 SLT: signed, result 1 or 0; computed from sub MSB xor overflow; overflow output forced 0.
  - 1000 MULU, 1001 DIVU.
  - All other codes: result 0, flags 0, single-cycle.
- Overflow: ADD/SUB = (a[MSB]==b'[MSB]) && (res[MSB]!=a[MSB]), where b' is b for ADD and ~b for SUB.
- Z:
  - outputAlu==0 for single-cycle ops.
  - For MULU: HI and LO both 0.
  - For DIVU: quotient==0.
- States: IDLE, MUL, DIV.
- Single-cycle ops:
  - start && !busy at edge k: results and flags registered at edge k.
  - done=1 for the cycle after edge k.
  - busy stays 0.
- MULU:
  - At edge k: operands latched, counter=WIDTH, busy=1, state MUL.
  - One shift-add iteration per edge.
  - At edge k+WIDTH: last iteration, {outputHi,outputAlu}=a*b (unsigned, 2*WIDTH bits), done=1, busy=0, IDLE.
  - Latency WIDTH cycles; busy high exactly WIDTH cycles.
- DIVU:
  - Restoring divide, same timing as MULU.
  - outputAlu=a/b, outputHi=a%b.
- DIVU with b=0:
  - No iteration; single-cycle.
  - outputAlu = all ones, outputHi=a, divByZero=1, Z=0.
- carryOut and overflow are 0 for MULU/DIVU. divByZero is 0 except as above.
- start while busy=1 is ignored (no queue, no effect on the running op).
- start in the same cycle that done is asserted is accepted (back-to-back).
- Outputs hold their last value until the next completing op or reset.
- done is never asserted for two consecutive cycles except for back-to-back single-cycle ops.

Test Plan:
- ADD, single-cycle: a=0xFFFFFFFF, b=0x00000001, carryIn=0, start at edge k.
  - After edge k: outputAlu=0, carryOut=1, Z=1, overflow=0, done=1 for one cycle, busy=0.
- SUB: a=0x80000000, b=1 -> outputAlu=0x7FFFFFFF, overflow=1, carryOut=1.
- SLT: a=0xA0000000, b=0xB0000000 -> outputAlu=1, overflow=0.
- Logic back-to-back, start held high each cycle:
  - AND 0xF0F0F0F0&0x0FF00FF0 -> 0x00F000F0.
  - NOR 0,0 -> 0xFFFFFFFF.
  - Expect done two consecutive cycles.
- MULU: a=b=0xFFFFFFFF, start at edge 10.
  - busy=1 for 32 cycles.
  - A second start at edge 15 (ADD) is ignored.
  - done only after edge 42: outputHi=0xFFFFFFFE, outputAlu=0x00000001, Z=0.
- DIVU:
  - a=100, b=7 -> after 32 cycles outputAlu=14, outputHi=2.
  - a=5, b=0 -> after 1 cycle outputAlu=0xFFFFFFFF, outputHi=5, divByZero=1, busy never high.
- Reset, then WIDTH=8:
  - rst_n low at cycle 15 of a MULU: all outputs 0 immediately; no done afterwards.
  - After release, ADD 3+4 -> 7.
  - Separate WIDTH=8 instance, MULU 0xFF*0xFF: done after 8 cycles, outputHi=0xFE, outputAlu=0x01.
